// File: rtl/fmo_tile_writer_if.sv
// Tile-writer bus: tile descriptor and start, pixel stream handshake,
// FMO RAM write port and status flags. Clock and reset stay outside.
interface fmo_tile_writer_if #(
    parameter int PX_W   = 16,
    parameter int ADDR_W = 16
) ();
    logic              start;
    logic [7:0]        fm_w;
    logic [7:0]        fm_h;
    logic [7:0]        tile_x0;
    logic [7:0]        tile_y0;
    logic [10:0]       ch_base;
    logic [5:0]        n_ch;
    logic              px_valid;
    logic [PX_W-1:0]   px_data;
    logic              px_ready;
    logic              fmo_we;
    logic [ADDR_W-1:0] fmo_addr;
    logic [PX_W-1:0]   fmo_din;
    logic              busy;
    logic              done;

    // Upstream side: controller plus PW output stage
    modport master (
        output start, fm_w, fm_h, tile_x0, tile_y0, ch_base, n_ch,
        output px_valid, px_data,
        input  px_ready, fmo_we, fmo_addr, fmo_din, busy, done
    );

    // Writer side
    modport slave (
        input  start, fm_w, fm_h, tile_x0, tile_y0, ch_base, n_ch,
        input  px_valid, px_data,
        output px_ready, fmo_we, fmo_addr, fmo_din, busy, done
    );
endinterface

// File: rtl/fmo_tile_writer.sv
// FMO tile writer: takes one Tox x Toy output tile for up to NPAR channels
// (order c, y, x) and writes it into the channel-planar FMO RAM, dropping
// pixels that lie beyond the right/bottom edge of the feature map.
// Optional build macro FMO_RELU_EN: clamp negative pixels to zero on write.
module fmo_tile_writer #(
    parameter int PX_W   = 16,
    parameter int TOX    = 7,
    parameter int TOY    = 7,
    parameter int NPAR   = 32,
    parameter int ADDR_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    fmo_tile_writer_if.slave bus
);
    localparam int XW = (TOX > 1) ? $clog2(TOX) : 1;
    localparam int YW = (TOY > 1) ? $clog2(TOY) : 1;
    localparam logic [5:0]    NPAR_C = 6'(NPAR);
    localparam logic [XW-1:0] X_LAST = XW'(TOX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(TOY - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        fm_w_q, fm_w_d, fm_h_q, fm_h_d;
    logic [7:0]        tx0_q, tx0_d, ty0_q, ty0_d;
    logic [10:0]       ch_base_q, ch_base_d;
    logic [5:0]        n_ch_q, n_ch_d;
    logic [15:0]       plane_q, plane_d;
    logic [ADDR_W-1:0] chan_base_q, chan_base_d;
    logic [ADDR_W-1:0] row_org_q, row_org_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [5:0]        c_q, c_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PX_W-1:0]   din_q, din_d;

    logic              ready_c, busy_c, done_c, accept_c, last_c, inb_c;
    logic [8:0]        col_c, row_c;
    logic [15:0]       plane_c;
    logic [31:0]       chan_prod_c, row_prod_c;
    logic [PX_W-1:0]   wdata_c;

    assign accept_c = bus.px_valid && (state_q == S_RUN);
    assign last_c   = (x_q == X_LAST) && (y_q == Y_LAST) && (c_q == n_ch_q - 6'd1);
    assign col_c    = 9'(tx0_q) + 9'(x_q);
    assign row_c    = 9'(ty0_q) + 9'(y_q);
    assign inb_c    = (col_c < 9'(fm_w_q)) && (row_c < 9'(fm_h_q));

    // Setup-only products; the per-pixel path below is add-only
    assign plane_c     = 16'(fm_w_q) * 16'(fm_h_q);
    assign chan_prod_c = 32'(ch_base_q) * 32'(plane_c);
    assign row_prod_c  = 32'(ty0_q) * 32'(fm_w_q);

`ifdef FMO_RELU_EN
    assign wdata_c = bus.px_data[PX_W-1] ? '0 : bus.px_data;
`else
    assign wdata_c = bus.px_data;
`endif

    // Control FSM: next state and status outputs
    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        busy_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = (bus.n_ch == 6'd0) ? S_DONE : S_SETUP;
            end
            S_SETUP: begin
                busy_c  = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                busy_c  = 1'b1;
                ready_c = 1'b1;
                if (accept_c && last_c) state_d = S_DONE;
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: descriptor latch, incremental address walk, write port
    always_comb begin
        fm_w_d      = fm_w_q;
        fm_h_d      = fm_h_q;
        tx0_d       = tx0_q;
        ty0_d       = ty0_q;
        ch_base_d   = ch_base_q;
        n_ch_d      = n_ch_q;
        plane_d     = plane_q;
        chan_base_d = chan_base_q;
        row_org_d   = row_org_q;
        row_base_d  = row_base_q;
        x_d         = x_q;
        y_d         = y_q;
        c_d         = c_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;

        if (state_q == S_IDLE && bus.start) begin
            fm_w_d    = bus.fm_w;
            fm_h_d    = bus.fm_h;
            tx0_d     = bus.tile_x0;
            ty0_d     = bus.tile_y0;
            ch_base_d = bus.ch_base;
            n_ch_d    = (bus.n_ch > NPAR_C) ? NPAR_C : bus.n_ch;
        end

        // row_org holds tile_y0*fm_w so each channel restarts at the tile's top row
        if (state_q == S_SETUP) begin
            plane_d     = plane_c;
            chan_base_d = chan_prod_c[ADDR_W-1:0];
            row_org_d   = row_prod_c[ADDR_W-1:0];
            row_base_d  = row_prod_c[ADDR_W-1:0];
            x_d         = '0;
            y_d         = '0;
            c_d         = '0;
        end

        if (accept_c) begin
            if (inb_c) begin
                we_d   = 1'b1;
                addr_d = chan_base_q + row_base_q + ADDR_W'(tx0_q) + ADDR_W'(x_q);
                din_d  = wdata_c;
            end
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d         = '0;
                    c_d         = c_q + 6'd1;
                    row_base_d  = row_org_q;
                    chan_base_d = chan_base_q + ADDR_W'(plane_q);
                end else begin
                    y_d        = y_q + YW'(1);
                    row_base_d = row_base_q + ADDR_W'(fm_w_q);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fm_w_q      <= '0;
            fm_h_q      <= '0;
            tx0_q       <= '0;
            ty0_q       <= '0;
            ch_base_q   <= '0;
            n_ch_q      <= '0;
            plane_q     <= '0;
            chan_base_q <= '0;
            row_org_q   <= '0;
            row_base_q  <= '0;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            fm_w_q      <= fm_w_d;
            fm_h_q      <= fm_h_d;
            tx0_q       <= tx0_d;
            ty0_q       <= ty0_d;
            ch_base_q   <= ch_base_d;
            n_ch_q      <= n_ch_d;
            plane_q     <= plane_d;
            chan_base_q <= chan_base_d;
            row_org_q   <= row_org_d;
            row_base_q  <= row_base_d;
            x_q         <= x_d;
            y_q         <= y_d;
            c_q         <= c_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
        end
    end

    assign bus.px_ready = ready_c;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.fmo_we   = we_q;
    assign bus.fmo_addr = addr_q;
    assign bus.fmo_din  = din_q;
endmodule

// File: tb/tb_fmo_tile_writer.sv
// Bench for fmo_tile_writer: a tile-level reference model derives every
// expected output from the closed-form address formula; a negedge process
// compares the DUT against it each cycle, and literal checks pin the model.
module tb_fmo_tile_writer;
    localparam int PX_W   = 16;
    localparam int TOX    = 7;
    localparam int TOY    = 7;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmo_tile_writer_if #(.PX_W(PX_W), .ADDR_W(ADDR_W)) bus ();

    fmo_tile_writer #(
        .PX_W(PX_W), .TOX(TOX), .TOY(TOY), .NPAR(32), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_SETUP, M_RUN, M_DONE} mph_t;
    mph_t        m_ph;
    int          m_fw, m_fh, m_tx, m_ty, m_cb, m_n, m_k;
    int          m_c, m_y, m_x, m_a;
    bit          m_we;
    logic [15:0] m_addr, m_din;

    function automatic logic [15:0] relu_ref(input logic [15:0] d);
`ifdef FMO_RELU_EN
        return (d[15] == 1'b1) ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = M_IDLE;
            m_we = 0;
            m_k  = 0;
        end else begin
            m_we = 0;
            case (m_ph)
                M_IDLE: if (bus.start) begin
                    m_fw = int'(bus.fm_w);   m_fh = int'(bus.fm_h);
                    m_tx = int'(bus.tile_x0); m_ty = int'(bus.tile_y0);
                    m_cb = int'(bus.ch_base); m_n  = int'(bus.n_ch);
                    m_ph = (m_n == 0) ? M_DONE : M_SETUP;
                end
                M_SETUP: begin
                    m_ph = M_RUN;
                    m_k  = 0;
                end
                M_RUN: if (bus.px_valid) begin
                    m_c = m_k / (TOX * TOY);
                    m_y = (m_k / TOX) % TOY;
                    m_x = m_k % TOX;
                    if ((m_tx + m_x < m_fw) && (m_ty + m_y < m_fh)) begin
                        m_a    = (m_cb + m_c) * m_fw * m_fh + (m_ty + m_y) * m_fw + (m_tx + m_x);
                        m_we   = 1;
                        m_addr = 16'(m_a);
                        m_din  = relu_ref(bus.px_data);
                    end
                    m_k++;
                    if (m_k == m_n * TOX * TOY) m_ph = M_DONE;
                end
                M_DONE: m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [15:0] log_addr[$];
    logic [15:0] log_din[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_px_ready", 32'(bus.px_ready), 32'd0);
            chk("rst_fmo_we",   32'(bus.fmo_we),   32'd0);
            chk("rst_fmo_addr", 32'(bus.fmo_addr), 32'd0);
            chk("rst_fmo_din",  32'(bus.fmo_din),  32'd0);
            chk("rst_busy",     32'(bus.busy),     32'd0);
            chk("rst_done",     32'(bus.done),     32'd0);
        end else begin
            chk("px_ready", 32'(bus.px_ready), 32'(m_ph == M_RUN));
            chk("busy",     32'(bus.busy),     32'(m_ph == M_SETUP || m_ph == M_RUN));
            chk("done",     32'(bus.done),     32'(m_ph == M_DONE));
            chk("fmo_we",   32'(bus.fmo_we),   32'(m_we));
            if (m_we) begin
                chk("fmo_addr", 32'(bus.fmo_addr), 32'(m_addr));
                chk("fmo_din",  32'(bus.fmo_din),  32'(m_din));
            end
            if (bus.fmo_we) begin
                log_addr.push_back(bus.fmo_addr);
                log_din.push_back(bus.fmo_din);
            end
            if (bus.done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] pix(input int mode, input int k);
        if (mode == 1 && k == 0) return 16'hFFF0;
        if (mode == 1 && k == 1) return 16'h0010;
        return 16'(k);
    endfunction

    int done0;

    task automatic run_tile(input int fw, input int fh, input int tx, input int ty,
                            input int cb, input int n, input bit bubbles,
                            input int rst_after, input bit dup_start, input int mode);
        int cyc;
        log_addr.delete();
        log_din.delete();
        done0 = done_cnt;
        @(negedge clk); #1;
        bus.fm_w    = 8'(fw);  bus.fm_h    = 8'(fh);
        bus.tile_x0 = 8'(tx);  bus.tile_y0 = 8'(ty);
        bus.ch_base = 11'(cb); bus.n_ch    = 6'(n);
        bus.start   = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (m_ph != M_IDLE && cyc < 3000) begin
            if (rst_after > 0 && m_k == rst_after && m_ph == M_RUN) begin
                bus.px_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("midrst_fmo_we",   32'(bus.fmo_we),   32'd0);
                chk("midrst_busy",     32'(bus.busy),     32'd0);
                chk("midrst_px_ready", 32'(bus.px_ready), 32'd0);
                @(negedge clk); #1;
                rst = 1'b0;
                return;
            end
            bus.px_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.px_data  = pix(mode, m_k);
            if (dup_start && m_k == 10) begin
                // second start with a different descriptor mid-tile
                bus.start = 1'b1;
                bus.fm_w  = 8'd3;
                bus.n_ch  = 6'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk); #1;
            cyc++;
        end
        bus.px_valid = 1'b0;
        bus.start    = 1'b0;
        if (cyc >= 3000) chk("tile_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.fm_w = '0; bus.fm_h = '0; bus.tile_x0 = '0;
        bus.tile_y0 = '0; bus.ch_base = '0; bus.n_ch = '0;
        bus.px_valid = 1'b0; bus.px_data = '0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        // interior tile, plus an ignored start mid-tile
        run_tile(14, 14, 7, 7, 3, 2, 0, 0, 1, 0);
        chk("t1_nwrites", 32'(log_addr.size()), 32'd98);
        chk("t1_first",   32'(log_addr[0]),     32'd693);
        chk("t1_ch1",     32'(log_addr[49]),    32'd889);
        chk("t1_last",    32'(log_addr[97]),    32'd979);
        chk("t1_din49",   32'(log_din[49]),     32'd49);
        chk("t1_done",    32'(done_cnt - done0), 32'd1);

        // right-edge clip
        run_tile(10, 7, 7, 0, 0, 1, 0, 0, 0, 0);
        chk("t2_nwrites", 32'(log_addr.size()), 32'd21);
        chk("t2_a0",      32'(log_addr[0]),     32'd7);
        chk("t2_a1",      32'(log_addr[1]),     32'd8);
        chk("t2_a2",      32'(log_addr[2]),     32'd9);
        chk("t2_a3",      32'(log_addr[3]),     32'd17);
        chk("t2_a20",     32'(log_addr[20]),    32'd69);
        chk("t2_din3",    32'(log_din[3]),      32'd7);

        // interior tile with bubbles
        run_tile(14, 14, 7, 7, 3, 2, 1, 0, 0, 0);
        chk("t3_nwrites", 32'(log_addr.size()), 32'd98);
        chk("t3_first",   32'(log_addr[0]),     32'd693);
        chk("t3_ch1",     32'(log_addr[49]),    32'd889);

        // empty channel group
        run_tile(14, 14, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_nwrites", 32'(log_addr.size()), 32'd0);
        chk("t4_done",    32'(done_cnt - done0), 32'd1);

        // reset after 20 accepts, then a full tile
        run_tile(14, 14, 7, 7, 3, 2, 0, 20, 0, 0);
        chk("t5_partial", 32'(log_addr.size()), 32'd20);
        run_tile(14, 14, 7, 7, 3, 2, 0, 0, 0, 0);
        chk("t5_nwrites", 32'(log_addr.size()), 32'd98);
        chk("t5_first",   32'(log_addr[0]),     32'd693);

        // write-path sign handling
        run_tile(7, 7, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("t6_nwrites", 32'(log_addr.size()), 32'd49);
`ifdef FMO_RELU_EN
        chk("t6_neg", 32'(log_din[0]), 32'h0000);
`else
        chk("t6_neg", 32'(log_din[0]), 32'hFFF0);
`endif
        chk("t6_pos", 32'(log_din[1]), 32'h0010);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
